mem_bus_arbiter: RTL and testbench

- Two-requester controller for the shared external memory bus (16-bit `bus_data`, 20-bit `bus_addr`, `read`/`write` strobes).
- Serialises accesses from two internal masters (e.g. instruction fetch and data port) onto the bus and runs a fixed-length bus cycle with optional wait states.
- Returns read data and a one-cycle acknowledge to the granted master.
- Sits between the CPU-side ports and every memory-mapped device on the bus; devices decode their own address ranges, read combinationally and write on the rising clock edge.

---
 rtl/mem_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//   Serialises accesses from two internal masters onto the shared external
//   memory bus. Each access is a fixed IDLE -> ACCESS -> DONE sequence. The
//   ACCESS phase lasts WAIT_STATES+1 cycles. DONE carries a one-cycle ack to
//   the granted master. When both masters request, they are granted in
//   alternating (round-robin) order.
//
// Parameters
//   WAIT_STATES  extra bus cycles per access (0..15)
//
// Ports
//   clk              system clock, rising edge
//   reset            synchronous, active-high reset
//   req0/req1        access request from master 0/1
//   we0/we1          1 = write, 0 = read (valid while req is high)
//   addr0/addr1      20-bit word address
//   wdata0/wdata1    16-bit write data
//   ack0/ack1        one-cycle completion pulse
//   rdata0/rdata1    captured read data, held until the next read for that master
//   bus_addr         shared bus address (0 when the bus is idle)
//   bus_data         shared bus data; driven only during a write ACCESS phase
//   read/write       bus strobes
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [19:0] addr0,
  input  logic [19:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic [19:0] bus_addr,
  inout  wire  [15:0] bus_data,
  output logic        read,
  output logic        write
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        last_grant;
  logic        grant_idx;
  logic        lat_idx;
  logic        lat_we;
  logic [19:0] lat_addr;
  logic [15:0] lat_wdata;
  logic [3:0]  wait_cnt;
  logic        any_req;
  logic        access_last;

  assign any_req     = req0 | req1;
  assign access_last = (wait_cnt == 4'd0);

  // On a tie the master that did not win last time gets the bus; a lone
  // requester always wins.
  assign grant_idx = (req0 && req1) ? ~last_grant : req1;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (access_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      lat_idx    <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      wait_cnt   <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_req) begin
            last_grant <= grant_idx;
            lat_idx    <= grant_idx;
            lat_we     <= grant_idx ? we1    : we0;
            lat_addr   <= grant_idx ? addr1  : addr0;
            lat_wdata  <= grant_idx ? wdata1 : wdata0;
            wait_cnt   <= 4'(WAIT_STATES);
          end
        end
        ACCESS: begin
          if (access_last) begin
            // The device has had the whole final cycle to settle its read.
            if (!lat_we) begin
              if (lat_idx) rdata1 <= bus_data;
              else         rdata0 <= bus_data;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus-side outputs decode only registered state, never the request inputs.
  assign read     = (state == ACCESS) && !lat_we;
  assign write    = (state == ACCESS) &&  lat_we;
  assign bus_addr = (state == ACCESS) ? lat_addr : 20'd0;
  assign bus_data = write ? lat_wdata : 16'hzzzz;

  assign ack0 = (state == DONE) && !lat_idx;
  assign ack1 = (state == DONE) &&  lat_idx;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter. Two instances are used: dut_a with
//   WAIT_STATES = 0 and dut_b with WAIT_STATES = 2. Each instance has its own
//   small word-addressed memory model on its bus. The model reads
//   combinationally and writes on the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- instance A: WAIT_STATES = 0 ----------------
  logic        reset_a;
  logic        req0_a, req1_a, we0_a, we1_a;
  logic [19:0] addr0_a, addr1_a;
  logic [15:0] wdata0_a, wdata1_a;
  logic        ack0_a, ack1_a;
  logic [15:0] rdata0_a, rdata1_a;
  logic [19:0] bus_addr_a;
  wire  [15:0] bus_data_a;
  logic        read_a, write_a;

  mem_bus_arbiter #(.WAIT_STATES(0)) dut_a (
    .clk(clk), .reset(reset_a),
    .req0(req0_a), .req1(req1_a), .we0(we0_a), .we1(we1_a),
    .addr0(addr0_a), .addr1(addr1_a), .wdata0(wdata0_a), .wdata1(wdata1_a),
    .ack0(ack0_a), .ack1(ack1_a), .rdata0(rdata0_a), .rdata1(rdata1_a),
    .bus_addr(bus_addr_a), .bus_data(bus_data_a),
    .read(read_a), .write(write_a)
  );

  // ---------------- instance B: WAIT_STATES = 2 ----------------
  logic        reset_b;
  logic        req0_b, req1_b, we0_b, we1_b;
  logic [19:0] addr0_b, addr1_b;
  logic [15:0] wdata0_b, wdata1_b;
  logic        ack0_b, ack1_b;
  logic [15:0] rdata0_b, rdata1_b;
  logic [19:0] bus_addr_b;
  wire  [15:0] bus_data_b;
  logic        read_b, write_b;

  mem_bus_arbiter #(.WAIT_STATES(2)) dut_b (
    .clk(clk), .reset(reset_b),
    .req0(req0_b), .req1(req1_b), .we0(we0_b), .we1(we1_b),
    .addr0(addr0_b), .addr1(addr1_b), .wdata0(wdata0_b), .wdata1(wdata1_b),
    .ack0(ack0_b), .ack1(ack1_b), .rdata0(rdata0_b), .rdata1(rdata1_b),
    .bus_addr(bus_addr_b), .bus_data(bus_data_b),
    .read(read_b), .write(write_b)
  );

  // ---------------- memory models ----------------
  // NOTE: the memory arrays have no reset; contents persist across arbiter
  // resets, just like real RAM on the bus.
  logic [15:0] mem_a [64];
  logic [15:0] mem_b [64];

  assign bus_data_a = read_a ? mem_a[bus_addr_a[5:0]] : 16'hzzzz;
  assign bus_data_b = read_b ? mem_b[bus_addr_b[5:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (write_a) mem_a[bus_addr_a[5:0]] <= bus_data_a;
    if (write_b) mem_b[bus_addr_b[5:0]] <= bus_data_b;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are stable 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_a = 1'b1; req0_a = 0; req1_a = 0; we0_a = 0; we1_a = 0;
    addr0_a = '0; addr1_a = '0; wdata0_a = '0; wdata1_a = '0;
    reset_b = 1'b1; req0_b = 0; req1_b = 0; we0_b = 0; we1_b = 0;
    addr0_b = '0; addr1_b = '0; wdata0_b = '0; wdata1_b = '0;
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = 16'h0000;
      mem_b[i] = 16'h0000;
    end
    mem_a[5] = 16'hBEEF;
    mem_a[3] = 16'h00FF;
    mem_b[3] = 16'h00FF;
    mem_b[5] = 16'hBEEF;

    tick(); tick();
    // ---- reset state ----
    check("rst_ack0",  {31'd0, ack0_a}, 32'd0);
    check("rst_ack1",  {31'd0, ack1_a}, 32'd0);
    check("rst_rdata0", {16'd0, rdata0_a}, 32'd0);
    check("rst_rdata1", {16'd0, rdata1_a}, 32'd0);
    check("rst_strobes", {30'd0, read_a, write_a}, 32'd0);
    check("rst_bus_addr", {12'd0, bus_addr_a}, 32'd0);
    reset_a = 1'b0;
    reset_b = 1'b0;
    tick();

    // ---- single read, W = 0 ----
    req0_a = 1; we0_a = 0; addr0_a = 20'h00005;
    tick();  // E0: grant
    check("rd_read_hi", {31'd0, read_a}, 32'd1);
    check("rd_bus_addr", {12'd0, bus_addr_a}, 32'h00005);
    check("rd_no_ack_yet", {31'd0, ack0_a}, 32'd0);
    tick();  // E1: DONE
    check("rd_ack0", {31'd0, ack0_a}, 32'd1);
    check("rd_ack1_lo", {31'd0, ack1_a}, 32'd0);
    check("rd_read_lo", {31'd0, read_a}, 32'd0);
    check("rd_rdata0", {16'd0, rdata0_a}, 32'h0000BEEF);
    req0_a = 0;
    tick();  // E2: IDLE
    check("rd_ack0_end", {31'd0, ack0_a}, 32'd0);
    check("rd_idle_addr", {12'd0, bus_addr_a}, 32'd0);

    // ---- master 1 write then read-back ----
    req1_a = 1; we1_a = 1; addr1_a = 20'h00010; wdata1_a = 16'h1234;
    tick();
    check("wr_write_hi", {31'd0, write_a}, 32'd1);
    check("wr_read_lo", {31'd0, read_a}, 32'd0);
    check("wr_bus_data", {16'd0, bus_data_a}, 32'h00001234);
    check("wr_bus_addr", {12'd0, bus_addr_a}, 32'h00010);
    tick();
    check("wr_ack1", {31'd0, ack1_a}, 32'd1);
    check("wr_write_lo", {31'd0, write_a}, 32'd0);
    check("wr_mem", {16'd0, mem_a[16]}, 32'h00001234);
    req1_a = 0;
    tick();
    req1_a = 1; we1_a = 0;
    tick();
    check("rb_read_hi", {31'd0, read_a}, 32'd1);
    tick();
    check("rb_ack1", {31'd0, ack1_a}, 32'd1);
    check("rb_rdata1", {16'd0, rdata1_a}, 32'h00001234);
    req1_a = 0;
    tick();

    // ---- tie after reset: grants 0,1,0,1 every 3 cycles ----
    reset_a = 1;
    tick();
    reset_a = 0;
    req0_a = 1; we0_a = 0; addr0_a = 20'h00005;
    req1_a = 1; we1_a = 0; addr1_a = 20'h00010;
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("tie_ack0_k%0d", k), {31'd0, ack0_a}, {31'd0, (k == 1 || k == 7)});
      check($sformatf("tie_ack1_k%0d", k), {31'd0, ack1_a}, {31'd0, (k == 4 || k == 10)});
      if (k == 1) check("tie_rdata0", {16'd0, rdata0_a}, 32'h0000BEEF);
      if (k == 4) check("tie_rdata1", {16'd0, rdata1_a}, 32'h00001234);
      if (k == 10) begin
        req0_a = 0;
        req1_a = 0;
      end
    end

    // ---- late input change ----
    req0_a = 1; we0_a = 0; addr0_a = 20'h00003;
    tick();
    addr0_a = 20'h00005;
    #1;
    check("late_bus_addr", {12'd0, bus_addr_a}, 32'h00003);
    tick();
    check("late_ack0", {31'd0, ack0_a}, 32'd1);
    check("late_rdata0", {16'd0, rdata0_a}, 32'h000000FF);
    req0_a = 0;
    tick();

    // ---- wait states (instance B, W = 2) ----
    req0_b = 1; we0_b = 0; addr0_b = 20'h00003;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("ws_read_k%0d", k), {31'd0, read_b}, 32'd1);
      check($sformatf("ws_noack_k%0d", k), {31'd0, ack0_b}, 32'd0);
    end
    tick();
    check("ws_read_lo", {31'd0, read_b}, 32'd0);
    check("ws_ack0", {31'd0, ack0_b}, 32'd1);
    check("ws_rdata0", {16'd0, rdata0_b}, 32'h000000FF);
    req0_b = 0;
    tick();

    // ---- reset mid-access (instance B) ----
    req0_b = 1; we0_b = 0; addr0_b = 20'h00003;
    tick();  // first ACCESS cycle
    tick();  // second ACCESS cycle
    check("mid_read_before", {31'd0, read_b}, 32'd1);
    reset_b = 1;
    req0_b = 0;
    tick();
    check("mid_strobes", {30'd0, read_b, write_b}, 32'd0);
    check("mid_ack", {30'd0, ack0_b, ack1_b}, 32'd0);
    check("mid_rdata0", {16'd0, rdata0_b}, 32'd0);
    check("mid_bus_addr", {12'd0, bus_addr_b}, 32'd0);
    reset_b = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("mid_quiet_k%0d", k), {29'd0, ack0_b, ack1_b, read_b}, 32'd0);
    end
    // fresh request completes normally
    req0_b = 1; we0_b = 0; addr0_b = 20'h00005;
    tick(); tick(); tick();
    check("fresh_read_hi", {31'd0, read_b}, 32'd1);
    tick();
    check("fresh_ack0", {31'd0, ack0_b}, 32'd1);
    check("fresh_rdata0", {16'd0, rdata0_b}, 32'h0000BEEF);
    req0_b = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Both acks must never be high together on either instance.
  always @(negedge clk) begin
    if ((ack0_a && ack1_a) || (ack0_b && ack1_b)) begin
      n_checks++;
      n_errors++;
      $display("FAIL both_acks: got a=%b%b b=%b%b expected no overlap",
               ack0_a, ack1_a, ack0_b, ack1_b);
    end
  end

endmodule
